scytale_encryption: RTL and testbench

//  Scytale (transposition) encryptor, the inverse of scytale_decryption. Buffers a

---
 rtl/scytale_pkg.sv | 20 ++
 rtl/scytale_idx_gen.sv | 67 ++++++
 rtl/scytale_encryption.sv | 128 ++++++++++++
 tb/tb_scytale_encryption.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/scytale_pkg.sv
// Shared constants and FSM encoding for the scytale encryption/decryption pair.
// Widths of the buffer pointer and the N*M product are derived here.
package scytale_pkg;

  localparam int D_WIDTH       = 8;
  localparam int KEY_WIDTH     = 8;
  localparam int MAX_NOF_CHARS = 50;
  localparam int LEN_W         = 2 * KEY_WIDTH;
  localparam int CNT_W         = $clog2(MAX_NOF_CHARS + 1);

  localparam logic [D_WIDTH-1:0] START_TOKEN = 8'hFA;
  localparam logic [CNT_W-1:0]   CNT_MAX     = CNT_W'(MAX_NOF_CHARS);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    EMIT    = 2'd1,
    DRAIN   = 2'd2
  } state_e;

endpackage

// File: rtl/scytale_idx_gen.sv
// Column-major read index generator for a row-major N x M buffer.
// Walks col 0..N-1, row 0..M-1 using only adds; one step per cycle while active.
module scytale_idx_gen
  import scytale_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [KEY_WIDTH-1:0] n_i,
  input  logic [KEY_WIDTH-1:0] m_i,
  output logic [CNT_W-1:0]     idx_o,
  output logic                 last_o
);

  logic                 active_q, active_d;
  logic [KEY_WIDTH-1:0] row_q, row_d;
  logic [KEY_WIDTH-1:0] col_q, col_d;
  logic [CNT_W-1:0]     idx_q, idx_d;
  logic [KEY_WIDTH-1:0] m_last;
  logic [KEY_WIDTH-1:0] n_last;

  assign m_last = m_i - 1'b1;
  assign n_last = n_i - 1'b1;
  assign last_o = active_q && (row_q == m_last) && (col_q == n_last);
  assign idx_o  = idx_q;

  // Only started when N*M fits the buffer, so every index stays below CNT_W range.
  always_comb begin
    active_d = active_q;
    row_d    = row_q;
    col_d    = col_q;
    idx_d    = idx_q;
    if (start_i) begin
      active_d = 1'b1;
      row_d    = '0;
      col_d    = '0;
      idx_d    = '0;
    end else if (active_q) begin
      if (last_o) begin
        active_d = 1'b0;
      end
      if (row_q == m_last) begin
        row_d = '0;
        col_d = col_q + 1'b1;
        idx_d = CNT_W'(col_q) + CNT_W'(1);
      end else begin
        row_d = row_q + 1'b1;
        idx_d = idx_q + CNT_W'(n_i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      row_q    <= '0;
      col_q    <= '0;
      idx_q    <= '0;
    end else begin
      active_q <= active_d;
      row_q    <= row_d;
      col_q    <= col_d;
      idx_q    <= idx_d;
    end
  end

endmodule

// File: rtl/scytale_encryption.sv
// Scytale encryptor: buffers plaintext row-wise until START_TOKEN, then emits it
// column-wise one byte per cycle. Length/key mismatches discard the buffer.
module scytale_encryption
  import scytale_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [D_WIDTH-1:0]   data_i,
  input  logic                 valid_i,
  input  logic [KEY_WIDTH-1:0] key_N,
  input  logic [KEY_WIDTH-1:0] key_M,
  output logic [D_WIDTH-1:0]   data_o,
  output logic                 valid_o,
  output logic                 busy
);

  // Handshake: no backpressure. A byte is taken on any posedge with valid_i=1
  // and busy=0; data_o is meaningful only on cycles with valid_o=1.

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [KEY_WIDTH-1:0] n_q, n_d;
  logic [KEY_WIDTH-1:0] m_q, m_d;
  logic [D_WIDTH-1:0]   data_o_q, data_o_d;
  logic                 valid_o_q, valid_o_d;
  logic [D_WIDTH-1:0]   mem_q [MAX_NOF_CHARS];

  logic                 wr_en;
  logic                 idx_start;
  logic [CNT_W-1:0]     idx;
  logic                 idx_last;
  logic                 accept;
  logic                 is_token;
  logic [LEN_W-1:0]     len;
  logic                 len_ok;

  // busy covers the final valid_o cycle, which is issued after state returns to COLLECT.
  assign busy     = (state_q != COLLECT) || valid_o_q;
  assign accept   = valid_i && !busy;
  assign is_token = (data_i == START_TOKEN);
  assign len      = LEN_W'(key_N) * LEN_W'(key_M);
  assign len_ok   = (len == LEN_W'(count_q)) && (key_N != '0) && (key_M != '0);

  assign data_o  = data_o_q;
  assign valid_o = valid_o_q;

  scytale_idx_gen u_idx_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (idx_start),
    .n_i     (n_q),
    .m_i     (m_q),
    .idx_o   (idx),
    .last_o  (idx_last)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    n_d       = n_q;
    m_d       = m_q;
    data_o_d  = data_o_q;
    valid_o_d = 1'b0;
    wr_en     = 1'b0;
    idx_start = 1'b0;
    case (state_q)
      COLLECT: begin
        if (accept) begin
          if (is_token) begin
            n_d = key_N;
            m_d = key_M;
            if (len_ok) begin
              state_d   = EMIT;
              idx_start = 1'b1;
            end else begin
              state_d = DRAIN;
            end
          end else if (count_q != CNT_MAX) begin
            wr_en   = 1'b1;
            count_d = count_q + 1'b1;
          end
        end
      end
      EMIT: begin
        valid_o_d = 1'b1;
        data_o_d  = mem_q[idx];
        if (idx_last) begin
          state_d = COLLECT;
          count_d = '0;
        end
      end
      DRAIN: begin
        count_d = '0;
        state_d = COLLECT;
      end
      default: begin
        state_d = COLLECT;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= COLLECT;
      count_q   <= '0;
      n_q       <= '0;
      m_q       <= '0;
      data_o_q  <= '0;
      valid_o_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      n_q       <= n_d;
      m_q       <= m_d;
      data_o_q  <= data_o_d;
      valid_o_q <= valid_o_d;
    end
  end

  // Buffer contents are don't-care after reset, so no reset on the array.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[count_q] <= data_i;
    end
  end

endmodule

// File: tb/tb_scytale_encryption.sv
// Directed bench for scytale_encryption: per-scenario tasks with inline checks
// against hand-computed ciphertext, busy length and valid_o timing.
module tb_scytale_encryption;
  import scytale_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [D_WIDTH-1:0]   data_i = '0;
  logic                 valid_i = 1'b0;
  logic [KEY_WIDTH-1:0] key_N = '0;
  logic [KEY_WIDTH-1:0] key_M = '0;
  logic [D_WIDTH-1:0]   data_o;
  logic                 valid_o;
  logic                 busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [D_WIDTH-1:0] exp_q[$];
  logic [D_WIDTH-1:0] got_q[$];
  int busy_cnt;
  int first_valid;
  bit gap;

  always #5 clk = ~clk;

  scytale_encryption dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_i  (data_i),
    .valid_i (valid_i),
    .key_N   (key_N),
    .key_M   (key_M),
    .data_o  (data_o),
    .valid_o (valid_o),
    .busy    (busy)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // All driver tasks start and end at a negedge.
  task automatic drive(input logic [D_WIDTH-1:0] b);
    data_i  = b;
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic send_msg(input string s, input logic [7:0] n, input logic [7:0] m);
    key_N = n;
    key_M = m;
    for (int i = 0; i < s.len(); i++) drive(s[i]);
    drive(START_TOKEN);
  endtask

  task automatic load_exp(input string s);
    exp_q.delete();
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  // Observation j=0 is the negedge right after the token edge; runs until busy drops.
  task automatic run_emit(input bit inject);
    bit seen_end;
    got_q.delete();
    busy_cnt    = 0;
    first_valid = -1;
    gap         = 1'b0;
    seen_end    = 1'b0;
    for (int j = 0; j < 200; j++) begin
      if (j > 0) begin
        @(negedge clk);
        valid_i = 1'b0;
      end
      if (valid_o) begin
        if (first_valid < 0) first_valid = j;
        if (seen_end) gap = 1'b1;
        got_q.push_back(data_o);
      end else if (first_valid >= 0) begin
        seen_end = 1'b1;
      end
      if (!busy) break;
      busy_cnt++;
      if (inject) begin
        if (j == 1) key_N = 8'd7;
        if (j == 2 || j == 8) begin data_i = 8'h51; valid_i = 1'b1; end
        if (j == 4) begin data_i = START_TOKEN; valid_i = 1'b1; end
      end
    end
    valid_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (valid_o !== 1'b0 || busy !== 1'b0 || data_o !== 8'h00)
      $display("FAIL reset_outputs got valid=%b busy=%b data=%h want 0 0 00", valid_o, busy, data_o);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_release_busy got %b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_basic;
    send_msg("ABCDEFGH", 8'd4, 8'd2);
    run_emit(1'b0);
    load_exp("AEBFCGDH");
    n_checks++;
    if (busy_cnt !== 9) $display("FAIL t1_busy_cycles got %0d want 9", busy_cnt);
    else n_pass++;
    n_checks++;
    if (first_valid !== 1) $display("FAIL t1_first_valid got %0d want 1", first_valid);
    else n_pass++;
    n_checks++;
    if (got_q.size() !== 8 || gap) $display("FAIL t1_len got %0d gap=%b want 8 gap=0", got_q.size(), gap);
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL t1_byte%0d got %h want %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_identity;
    send_msg("XYZ", 8'd1, 8'd3);
    run_emit(1'b0);
    load_exp("XYZ");
    n_checks++;
    if (busy_cnt !== 4 || got_q.size() !== 3) $display("FAIL t2a_shape got busy=%0d len=%0d want 4 3", busy_cnt, got_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL t2a_byte%0d got %h want %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
    send_msg("XYZ", 8'd3, 8'd1);
    run_emit(1'b0);
    n_checks++;
    if (busy_cnt !== 4 || got_q.size() !== 3) $display("FAIL t2b_shape got busy=%0d len=%0d want 4 3", busy_cnt, got_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL t2b_byte%0d got %h want %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_mismatch;
    send_msg("ABCDE", 8'd2, 8'd2);
    run_emit(1'b0);
    n_checks++;
    if (busy_cnt !== 1 || got_q.size() !== 0) $display("FAIL t3_drain got busy=%0d len=%0d want 1 0", busy_cnt, got_q.size());
    else n_pass++;
    send_msg("WXYZ", 8'd2, 8'd2);
    run_emit(1'b0);
    load_exp("WYXZ");
    n_checks++;
    if (busy_cnt !== 5 || got_q.size() !== 4) $display("FAIL t3_next_shape got busy=%0d len=%0d want 5 4", busy_cnt, got_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL t3_byte%0d got %h want %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_ignore_while_busy;
    send_msg("ABCDEFGH", 8'd4, 8'd2);
    run_emit(1'b1);
    load_exp("AEBFCGDH");
    n_checks++;
    if (busy_cnt !== 9 || got_q.size() !== 8 || gap)
      $display("FAIL t4_shape got busy=%0d len=%0d gap=%b want 9 8 0", busy_cnt, got_q.size(), gap);
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL t4_byte%0d got %h want %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
    send_msg("WXYZ", 8'd2, 8'd2);
    run_emit(1'b0);
    load_exp("WYXZ");
    n_checks++;
    if (busy_cnt !== 5 || got_q.size() !== 4) $display("FAIL t4_next_shape got busy=%0d len=%0d want 5 4", busy_cnt, got_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL t4_next_byte%0d got %h want %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_overflow;
    key_N = 8'd5;
    key_M = 8'd10;
    for (int i = 1; i <= 52; i++) drive(8'(i));
    drive(START_TOKEN);
    run_emit(1'b0);
    // Stored byte k holds value k+1; read order is column-major over 10 rows of 5.
    exp_q.delete();
    for (int c = 0; c < 5; c++)
      for (int r = 0; r < 10; r++) exp_q.push_back(8'(r * 5 + c + 1));
    n_checks++;
    if (busy_cnt !== 51 || got_q.size() !== 50 || gap)
      $display("FAIL t5_shape got busy=%0d len=%0d gap=%b want 51 50 0", busy_cnt, got_q.size(), gap);
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL t5_byte%0d got %h want %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_zero_key;
    send_msg("", 8'd0, 8'd5);
    run_emit(1'b0);
    n_checks++;
    if (busy_cnt !== 1 || got_q.size() !== 0) $display("FAIL zero_key got busy=%0d len=%0d want 1 0", busy_cnt, got_q.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid_emit;
    bit stray;
    send_msg("ABCDEFGH", 8'd4, 8'd2);
    repeat (3) @(negedge clk);
    n_checks++;
    if (valid_o !== 1'b1 || data_o !== 8'h42) $display("FAIL t6_third_valid got valid=%b data=%h want 1 42", valid_o, data_o);
    else n_pass++;
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (valid_o !== 1'b0 || busy !== 1'b0) $display("FAIL t6_abort got valid=%b busy=%b want 0 0", valid_o, busy);
    else n_pass++;
    rst_n = 1'b1;
    stray = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (valid_o !== 1'b0 || busy !== 1'b0) stray = 1'b1;
    end
    n_checks++;
    if (stray) $display("FAIL t6_after_abort got stray valid/busy want none");
    else n_pass++;
    send_msg("ABCDEFGH", 8'd4, 8'd2);
    run_emit(1'b0);
    load_exp("AEBFCGDH");
    n_checks++;
    if (busy_cnt !== 9 || first_valid !== 1 || got_q.size() !== 8)
      $display("FAIL t6_rerun_shape got busy=%0d first=%0d len=%0d want 9 1 8", busy_cnt, first_valid, got_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL t6_byte%0d got %h want %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_identity();
    test_mismatch();
    test_ignore_while_busy();
    test_overflow();
    test_zero_key();
    test_reset_mid_emit();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
